avalon_mm_instmem_slave: RTL
============================

# avalon_mm_instmem_slave

Avalon-MM slave (responder) that fronts the on-chip instruction memory and serves fetch reads issued by the processor's Avalon-MM instruction master. It inserts a programmable number of wait states using `s_waitrequest`, registers and holds read data, and flags out-of-range or illegal accesses. An optional write path lets the program be loaded over the same bus.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: wait states inserted before acknowledge; legal range 0–15.
- `BASE_ADDR`, default 32'h0000_0000: byte base address of the memory window.
- `INIT_FILE`, default "": hex image loaded with `$readmemh` at elaboration when non-empty.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_address` in 32: byte address.
- `s_read` in 1: read request.
- `s_write` in 1: write request.
- `s_writedata` in 32: write data.
- `s_byteenable` in 4: byte lanes for writes.
- `s_readdata` out 32: registered read data, held until the next read acknowledge.
- `s_waitrequest` out 1: high means the transfer is not accepted.
- `err_addr` out 1: sticky error flag; cleared only by reset.

## Operation
- **Word index:** `(s_address - BASE_ADDR) >> 2`; bits [1:0] are ignored.
- **In range:** `BASE_ADDR <= s_address < BASE_ADDR + 4*2^ADDR_WIDTH`.
- **FSM states:** IDLE, WAIT, ACK.
- **IDLE:**
  - On `s_read | s_write`, latch address, command, data and byteenable.
  - Load `wait_cnt = WAIT_CYCLES`.
  - Go to WAIT if WAIT_CYCLES > 0, otherwise go to ACK.
- **WAIT:**
  - Decrement `wait_cnt`; go to ACK when it reaches 1.
  - If `s_read` and `s_write` are both low, abort to IDLE with no effect.
- **ACK:**
  - `s_waitrequest` = 0 for exactly one cycle.
  - Read: `s_readdata` is already loaded with `mem[index]` on the IDLE/WAIT→ACK transition.
  - Write: memory is updated per `s_byteenable` in this cycle (when enabled, see Configuration).
  - Next state is always IDLE.
- **Latched operands:** the latched address is used. Changes on `s_address`/`s_writedata` after the IDLE cycle are ignored.
- **Out-of-range read:** completes normally, `s_readdata` = 32'h0000_0000, `err_addr` set.
- **Out-of-range write:** completes normally, memory unchanged, `err_addr` set.
- **`s_read` and `s_write` both high at IDLE:** treated as a read; the write is dropped and `err_addr` is set.
- **Back-to-back:** a request still high in the IDLE cycle after ACK starts a new transfer. Throughput is one transfer per WAIT_CYCLES+2 cycles.

## Timing
- **Reset values:** `s_waitrequest` = 1, `s_readdata` = 32'h0, `err_addr` = 0, FSM = IDLE, `wait_cnt` = 0. Memory contents are not reset.
- `s_waitrequest` is 1 in IDLE and WAIT, and 0 only in ACK.
- **Latency:** request first sampled at edge T0 → ACK cycle begins at edge T0+WAIT_CYCLES+1 (at T0+1 for WAIT_CYCLES = 0).
- `s_readdata` is valid in the ACK cycle and stays stable until the next read ACK. This supports masters that sample data one cycle after `waitrequest` falls.
- **Reset asserted mid-transfer:**
  - Immediate return to IDLE with reset output values.
  - A pending write is lost; any byte lanes already written stay written.
- **Counter rules:**
  - `wait_cnt` is 4 bits and never wraps.
  - Address subtraction is 32-bit unsigned; an address below `BASE_ADDR` underflows to a large value and is therefore out of range.

## Configuration
- **`INSTMEM_WRITE_EN` defined:** writes update memory byte-wise per `s_byteenable` in the ACK cycle.
- **`INSTMEM_WRITE_EN` undefined:**
  - No memory write port is synthesized (pure ROM).
  - Writes still handshake identically (same wait states, one ACK cycle) but have no effect.
  - In-range writes do not set `err_addr`.

## Test plan
- **Read, default wait:** WAIT_CYCLES = 2, mem[5] = 32'hA5A5_0013. Read addr 0x14 at T0 → `s_waitrequest` low only at T3, `s_readdata` = 32'hA5A5_0013 at T3 and still at T4.
- **Zero wait, back-to-back:** WAIT_CYCLES = 0, `s_read` held high over addr 0x0 then 0x4 → ACKs at T1 and T3, data mem[0] then mem[1].
- **Out-of-range read:** ADDR_WIDTH = 10, read addr 0x1000 → completes with `s_readdata` = 0 and `err_addr` = 1, which stays 1 through a following legal read.
- **Byte write (`INSTMEM_WRITE_EN`):** write 32'h1122_3344 with byteenable 4'b0101 to 0x8 (old 32'hFFFF_FFFF), then read → 32'hFF22_FF44. Without the macro, the read returns 32'hFFFF_FFFF.
- **Abort:** WAIT_CYCLES = 4, `s_read` dropped at T2 → no ACK, FSM back in IDLE, `s_readdata` unchanged.
- **Reset mid-transfer:** `reset_n` pulsed low at T1 of a read → `s_waitrequest` = 1, `s_readdata` = 0 immediately. The next read completes normally.

Source files
------------

// File: rtl/avalon_mm_instmem_slave.sv
// Avalon-MM instruction-memory responder with programmable wait states.
// Read data is registered and held until the next read acknowledge.
// err_addr is sticky; it flags out-of-range accesses and read+write collisions.
// Optional feature macro: INSTMEM_WRITE_EN adds a byte-lane write port. Without
// it the memory is a pure ROM, and writes still handshake but have no effect.
module avalon_mm_instmem_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic [3:0]  s_byteenable,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic        err_addr
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        wreq_q;
  logic        err_q;

  logic [31:0] mem_q [Depth];

  logic [31:0]           dec_addr;
  logic [31:0]           dec_off;
  logic [ADDR_WIDTH-1:0] dec_idx;
  logic                  in_range;
  logic                  cmd_rd;
  logic                  cmd_wr;
  logic                  req;
  logic                  go_ack;

  // Decode the live bus in IDLE (needed for zero-wait reads), the latched copy afterwards.
  always_comb begin
    if (state_q == StIdle) begin
      dec_addr = s_address;
      cmd_rd   = s_read;
      cmd_wr   = s_write;
    end else begin
      dec_addr = addr_q;
      cmd_rd   = rd_q;
      cmd_wr   = wr_q;
    end
    // An address below BASE_ADDR wraps to a huge offset and falls out of range.
    dec_off  = dec_addr - BASE_ADDR;
    in_range = (dec_off >> (ADDR_WIDTH + 2)) == 32'd0;
    dec_idx  = dec_off[ADDR_WIDTH+1:2];
  end

  // Decide whether this edge moves the FSM into the acknowledge cycle.
  always_comb begin
    req    = s_read | s_write;
    go_ack = 1'b0;
    unique case (state_q)
      StIdle:  go_ack = req && (WAIT_CYCLES == 0);
      StWait:  go_ack = req && (cnt_q <= 4'd1);
      default: go_ack = 1'b0;
    endcase
  end

  // Handshake FSM with registered waitrequest, read data and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      wreq_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= s_address;
            rd_q    <= s_read;
            wr_q    <= s_write;
            cnt_q   <= WaitInit;
            state_q <= (WAIT_CYCLES == 0) ? StAck : StWait;
          end
        end
        StWait: begin
          if (!req) begin
            // Master withdrew the request: drop it silently.
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_q <= StAck;
          end
        end
        StAck: begin
          state_q <= StIdle;
          wreq_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase

      if (go_ack) begin
        wreq_q <= 1'b0;
        if (cmd_rd) rdata_q <= in_range ? mem_q[dec_idx] : 32'd0;
        // A read+write collision is served as a read and flagged.
        if (!in_range || (cmd_rd && cmd_wr)) err_q <= 1'b1;
      end
    end
  end

`ifdef INSTMEM_WRITE_EN
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  // Capture write operands with the command so later bus changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (state_q == StIdle && req) begin
      wdata_q <= s_writedata;
      be_q    <= s_byteenable;
    end
  end

  // Commit the write byte-wise at the end of the acknowledge cycle.
  always_ff @(posedge clk) begin
    if (state_q == StAck && wr_q && !rd_q && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[dec_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{s_writedata, s_byteenable};
`endif

  assign s_readdata    = rdata_q;
  assign s_waitrequest = wreq_q;
  assign err_addr      = err_q;

endmodule
